// File: rtl/window_stream_gen.sv
// window_stream_gen
// Streaming KxK sliding-window generator. Pixels arrive one per accepted
// cycle in raster order. K-1 line memories hold the previous rows of each
// column. A KxK register window shifts left on every accepted pixel. The
// window that ends at the most recent pixel is presented one cycle after
// the accepting edge.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset_n    : synchronous, active-low reset
//   pix_valid  : pix_data / pix_sof are meaningful this cycle
//   pix_sof    : current pixel is (row 0, col 0) of a frame
//   pix_data   : input pixel
//   win_valid  : win_data holds a complete in-image window
//   win_data   : KxK window; element (r,c) at [((K*K-1)-(r*K+c))*PIXEL_BITS +: PIXEL_BITS]
//   win_row    : row of the window's bottom-right pixel
//   win_col    : column of the window's bottom-right pixel
//   frame_done : one-cycle pulse with the output of the last pixel of a frame
//   frame_err  : one-cycle pulse when pix_sof arrives with counters not at (0,0)
module window_stream_gen #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int KERNEL_SIZE = 7,
  parameter int PIXEL_BITS  = 10,
  parameter int COL_BITS    = $clog2(IMG_WIDTH),
  parameter int ROW_BITS    = $clog2(IMG_HEIGHT)
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          pix_valid,
  input  logic                                          pix_sof,
  input  logic [PIXEL_BITS-1:0]                         pix_data,
  output logic                                          win_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_BITS-1:0] win_data,
  output logic [ROW_BITS-1:0]                           win_row,
  output logic [COL_BITS-1:0]                           win_col,
  output logic                                          frame_done,
  output logic                                          frame_err
);

  localparam int K        = KERNEL_SIZE;
  localparam int WIN_BITS = K * K * PIXEL_BITS;

  logic [ROW_BITS-1:0]   row_cnt_r;
  logic [COL_BITS-1:0]   col_cnt_r;
  logic [ROW_BITS-1:0]   acc_row_s;
  logic [COL_BITS-1:0]   acc_col_s;
  logic [ROW_BITS-1:0]   nxt_row_s;
  logic [COL_BITS-1:0]   nxt_col_s;
  logic                  last_col_s;
  logic                  last_row_s;
  logic                  at_origin_s;

  logic [PIXEL_BITS-1:0] line_rd_s  [K-1];
  logic [PIXEL_BITS-1:0] new_col_s  [K];
  logic [PIXEL_BITS-1:0] win_r      [K][K];
  logic [WIN_BITS-1:0]   win_data_s;

  logic                  win_valid_r;
  logic                  frame_done_r;
  logic                  frame_err_r;
  logic [ROW_BITS-1:0]   win_row_r;
  logic [COL_BITS-1:0]   win_col_r;

  // Coordinates of the pixel offered this cycle and the counter values that follow it
  always_comb begin
    acc_row_s   = row_cnt_r;
    acc_col_s   = col_cnt_r;
    nxt_row_s   = row_cnt_r;
    nxt_col_s   = col_cnt_r;
    at_origin_s = (row_cnt_r == {ROW_BITS{1'b0}}) && (col_cnt_r == {COL_BITS{1'b0}});
    if (pix_sof) begin
      // A start-of-frame pixel is (0,0) no matter where the counters were.
      acc_row_s = {ROW_BITS{1'b0}};
      acc_col_s = {COL_BITS{1'b0}};
    end else begin
      acc_row_s = row_cnt_r;
      acc_col_s = col_cnt_r;
    end
    last_col_s = (acc_col_s == COL_BITS'(IMG_WIDTH - 1));
    last_row_s = (acc_row_s == ROW_BITS'(IMG_HEIGHT - 1));
    if (last_col_s) begin
      nxt_col_s = {COL_BITS{1'b0}};
      if (last_row_s) begin
        nxt_row_s = {ROW_BITS{1'b0}};
      end else begin
        nxt_row_s = acc_row_s + ROW_BITS'(1);
      end
    end else begin
      nxt_col_s = acc_col_s + COL_BITS'(1);
      nxt_row_s = acc_row_s;
    end
  end

  // Raster position counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_cnt_r <= {ROW_BITS{1'b0}};
      col_cnt_r <= {COL_BITS{1'b0}};
    end else if (pix_valid) begin
      row_cnt_r <= nxt_row_s;
      col_cnt_r <= nxt_col_s;
    end else begin
      row_cnt_r <= row_cnt_r;
      col_cnt_r <= col_cnt_r;
    end
  end

  // Line memories: each column ages one row per accepted pixel. mem[0] holds the
  // row just above the current one. Each memory is a plain 1R1W RAM. The read is
  // asynchronous, so the old contents are read before the write in the same cycle.
  for (genvar gk = 0; gk < K - 1; gk++) begin : g_line
    logic [PIXEL_BITS-1:0] mem_r [IMG_WIDTH];
    logic [PIXEL_BITS-1:0] wr_data_s;

    if (gk == 0) begin : g_head
      assign wr_data_s = pix_data;
    end else begin : g_tail
      assign wr_data_s = line_rd_s[gk-1];
    end

    assign line_rd_s[gk] = mem_r[acc_col_s];

    // Write the aged column entry on accept
    always_ff @(posedge clk) begin
      if (reset_n && pix_valid) begin
        mem_r[acc_col_s] <= wr_data_s;
      end
    end
  end

  // New right-hand window column, oldest row on top, current pixel at the bottom
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col_s[r] = line_rd_s[K-2-r];
    end
    new_col_s[K-1] = pix_data;
  end

  // Window registers shift left one column per accepted pixel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_r[r][c] <= {PIXEL_BITS{1'b0}};
        end
      end
    end else if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_r[r][c] <= win_r[r][c+1];
        end
        win_r[r][K-1] <= new_col_s[r];
      end
    end else begin
      win_r <= win_r;
    end
  end

  // Status outputs: pulses drop on idle cycles, coordinates hold.
  // Any stale line data belongs to rows above the frame. The row >= K-1 test
  // keeps it out of valid windows. The col >= K-1 test stops a window from
  // straddling a row wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      win_row_r    <= {ROW_BITS{1'b0}};
      win_col_r    <= {COL_BITS{1'b0}};
    end else if (pix_valid) begin
      win_valid_r  <= (acc_row_s >= ROW_BITS'(K - 1)) && (acc_col_s >= COL_BITS'(K - 1));
      frame_done_r <= last_row_s && last_col_s;
      frame_err_r  <= pix_sof && !at_origin_s;
      win_row_r    <= acc_row_s;
      win_col_r    <= acc_col_s;
    end else begin
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      win_row_r    <= win_row_r;
      win_col_r    <= win_col_r;
    end
  end

  // Flatten the register window so the newest pixel lands at the LSBs
  always_comb begin
    win_data_s = {WIN_BITS{1'b0}};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_data_s[((K*K-1)-(r*K+c))*PIXEL_BITS +: PIXEL_BITS] = win_r[r][c];
      end
    end
  end

  assign win_valid  = win_valid_r;
  assign win_data   = win_data_s;
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_window_stream_gen.sv
// tb_window_stream_gen
// Directed bench for window_stream_gen with W=8, H=6, K=3, 8-bit pixels.
// Pixel value = row*16+col, or 0xFF minus that for the alternate frame.
// The driver pushes the expected output for every pixel that should show up
// (valid window or framing error). The negedge monitor pops and compares.
module tb_window_stream_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int PB = 8;
  localparam int WB = K * K * PB;

  logic          clk;
  logic          reset_n;
  logic          pix_valid;
  logic          pix_sof;
  logic [PB-1:0] pix_data;
  logic          win_valid;
  logic [WB-1:0] win_data;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          frame_done;
  logic          frame_err;

  window_stream_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .PIXEL_BITS(PB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .win_valid(win_valid), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic          v;
    logic          e;
    logic          d;
    logic [2:0]    row;
    logic [2:0]    col;
    logic [WB-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            done_cyc[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            valid_seen = 0;
  int            err_seen = 0;
  logic          first_win_seen = 1'b0;
  logic [WB-1:0] first_win = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PB-1:0] pix_f(int sel, int r, int c);
    logic [PB-1:0] p;
    p = 8'(r * 16 + c);
    return (sel != 0) ? (8'hFF - p) : p;
  endfunction

  // Hand-derived window: element (i,j) is pixel (r-2+i, c-2+j) of the same frame
  function automatic logic [WB-1:0] exp_win(int sel, int r, int c);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[((K*K-1)-(i*K+j))*PB +: PB] = pix_f(sel, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pop one expectation per presented output
  always @(negedge clk) begin
    exp_t e;
    if (win_valid || frame_err) begin
      if (win_valid) valid_seen++;
      if (frame_err) err_seen++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got valid=%0b err=%0b at (%0d,%0d) expected none",
                 win_valid, frame_err, win_row, win_col);
      end else begin
        e = sb_q.pop_front();
        check("meta{v,err,done,row,col}", WB'({win_valid, frame_err, frame_done, win_row, win_col}),
              WB'({e.v, e.e, e.d, e.row, e.col}));
        if (e.v) check("window_data", win_data, e.data);
      end
      if (win_valid && !first_win_seen) begin
        first_win_seen = 1'b1;
        first_win      = win_data;
      end
    end else if (frame_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL lone_frame_done: got 1 at (%0d,%0d) expected 0", win_row, win_col);
    end
    if (frame_done) done_cyc.push_back(cyc);
  end

  task automatic send(input logic [PB-1:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Idle cycle with junk on the data/sof lines, which must be ignored
  task automatic idle();
    pix_valid = 1'b0;
    pix_sof   = 1'($urandom_range(1, 0));
    pix_data  = 8'($urandom);
    @(posedge clk);
    #1;
    pix_sof   = 1'b0;
  endtask

  task automatic run_frame(input int sel, input bit sof_first, input bit err_first,
                           input bit gaps, input int n_pix);
    exp_t e;
    for (int idx = 0; idx < n_pix; idx++) begin
      int r;
      int c;
      r = idx / W;
      c = idx % W;
      if (gaps) repeat ($urandom_range(2, 0)) idle();
      if ((r >= K - 1 && c >= K - 1) || (err_first && idx == 0)) begin
        e.v    = (r >= K - 1 && c >= K - 1);
        e.e    = err_first && (idx == 0);
        e.d    = (r == H - 1) && (c == W - 1);
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.data = e.v ? exp_win(sel, r, c) : '0;
        sb_q.push_back(e);
      end
      send(pix_f(sel, r, c), sof_first && (idx == 0));
    end
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    check(name, WB'(sb_q.size()), WB'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_win_valid"}, WB'(win_valid), WB'(0));
    check({tag, "_win_data"}, win_data, WB'(0));
    check({tag, "_win_row"}, WB'(win_row), WB'(0));
    check({tag, "_win_col"}, WB'(win_col), WB'(0));
    check({tag, "_frame_done"}, WB'(frame_done), WB'(0));
    check({tag, "_frame_err"}, WB'(frame_err), WB'(0));
  endtask

  initial begin
    int v0;
    int e0;
    int d0;
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Continuous frame with sof
    v0 = valid_seen; e0 = err_seen; d0 = done_cyc.size();
    run_frame(0, 1'b1, 1'b0, 1'b0, W * H);
    drain("t1_queue_empty");
    check("t1_valid_count", WB'(valid_seen - v0), WB'(24));
    check("t1_first_window", first_win, 72'h00_01_02_10_11_12_20_21_22);
    check("t1_done_count", WB'(done_cyc.size() - d0), WB'(1));
    check("t1_err_count", WB'(err_seen - e0), WB'(0));

    // Same frame with random gaps
    v0 = valid_seen; d0 = done_cyc.size();
    run_frame(0, 1'b1, 1'b0, 1'b1, W * H);
    drain("t2_queue_empty");
    check("t2_valid_count", WB'(valid_seen - v0), WB'(24));
    check("t2_done_count", WB'(done_cyc.size() - d0), WB'(1));

    // sof reasserted at (3,4): new frame (inverted data) restarts there
    v0 = valid_seen; e0 = err_seen;
    run_frame(0, 1'b1, 1'b0, 1'b0, 3 * W + 4);
    run_frame(1, 1'b1, 1'b1, 1'b0, W * H);
    drain("t3_queue_empty");
    check("t3_valid_count", WB'(valid_seen - v0), WB'(8 + 24));
    check("t3_err_count", WB'(err_seen - e0), WB'(1));

    // Reset at (4,5), then a frame without sof
    run_frame(0, 1'b1, 1'b0, 1'b0, 4 * W + 5);
    reset_n   = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'hAA;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    check_outputs_zero("midreset");
    reset_n = 1'b1;
    v0 = valid_seen;
    run_frame(0, 1'b0, 1'b0, 1'b0, W * H);
    drain("t4_queue_empty");
    check("t4_valid_count", WB'(valid_seen - v0), WB'(24));

    // Back-to-back frames, second with inverted data
    d0 = done_cyc.size(); e0 = err_seen;
    run_frame(0, 1'b1, 1'b0, 1'b0, W * H);
    run_frame(1, 1'b1, 1'b0, 1'b0, W * H);
    drain("t5_queue_empty");
    check("t5_done_count", WB'(done_cyc.size() - d0), WB'(2));
    if (done_cyc.size() - d0 == 2)
      check("t5_done_spacing", WB'(done_cyc[d0+1] - done_cyc[d0]), WB'(48));
    check("t5_err_count", WB'(err_seen - e0), WB'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/window_stream_gen.md
Name: window_stream_gen

Overview:
- Streaming 2-D sliding-window generator for the real-time filter pipeline.
- Accepts one pixel per handshake in raster order and keeps K-1 line memories plus a KxK register window.
- Presents the full KxK neighbourhood ending at the current pixel to the downstream filter kernel.
- Adds per-pixel valid, frame-start sync, window coordinates, frame-done and framing-error signalling.

Parameters:
- IMG_WIDTH, 640, pixels per row (>= KERNEL_SIZE)
- IMG_HEIGHT, 480, rows per frame (>= KERNEL_SIZE)
- KERNEL_SIZE, 7, window edge K; odd, 3..15
- PIXEL_BITS, 10, bits per pixel
- COL_BITS, $clog2(IMG_WIDTH), column counter width
- ROW_BITS, $clog2(IMG_HEIGHT), row counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset; synchronous, active-low
- pix_valid  in  1  pix_data/pix_sof qualify this cycle
- pix_sof  in  1  current pixel is (row 0, col 0) of a frame
- pix_data  in  PIXEL_BITS  input pixel, raster order
- win_valid  out  1  win_data holds a complete in-image window
- win_data  out  K*K*PIXEL_BITS  window; element (r,c) at bits [((K*K-1)-(r*K+c))*PIXEL_BITS +: PIXEL_BITS]; r=0 top/oldest row, c=0 leftmost; (K-1,K-1) = newest pixel at LSBs
- win_row  out  ROW_BITS  row of window's bottom-right pixel
- win_col  out  COL_BITS  column of window's bottom-right pixel
- frame_done  out  1  one-cycle pulse with the last pixel's output of a frame
- frame_err  out  1  one-cycle pulse: pix_sof seen when counters not at (0,0)

Behaviour:
- Reset (reset_n=0 at clk edge): all outputs 0; row/col counters 0; window registers 0; line-memory contents need not be cleared. Reset mid-frame discards the partial frame; next accepted pixel is treated as (0,0) regardless of pix_sof.
- Accept: pixel accepted iff pix_valid=1 at clk edge. pix_valid=0: counters, window, line memories hold; win_valid, frame_done, frame_err drop to 0 next cycle; win_data/win_row/win_col hold.
- Coordinates: accepted pixel takes (row_cnt, col_cnt); col increments, wraps at IMG_WIDTH-1 to 0 and increments row; row wraps at IMG_HEIGHT-1 to 0 (self-framing without pix_sof).
- pix_sof with pix_valid: pixel forced to (0,0); counters continue from (0,1). If counters were not (0,0), frame_err pulses with that pixel's output. pix_sof without pix_valid is ignored.
- Line memories: K-1 rows of IMG_WIDTH x PIXEL_BITS, addressed by col; on accept, column col shifts one row older (mem[k] <= mem[k-1], mem[0] <= pix_data); read-before-write in the same cycle. Inferable as RAM (one read + one write port each).
- Window: on accept, every window row shifts left one column; new right column = {mem[K-2][col], ..., mem[0][col], pix_data} top to bottom.
- Latency: outputs register exactly 1 cycle after the accepting edge.
- win_valid=1 iff accepted pixel has row >= K-1 and col >= K-1; windows never straddle a row wrap (suppressed at col < K-1). Exactly (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1) win_valid pulses per frame.
- win_row/win_col update on every accepted pixel, valid or not.
- frame_done=1 when accepted pixel is (IMG_HEIGHT-1, IMG_WIDTH-1); coincides with the last win_valid of the frame.
- Back-to-back frames with no gap: first pixel of frame n+1 may be accepted the cycle after the last of frame n. Stale line data must not reach a valid window.

Test Plan:
- Use IMG_WIDTH=8, IMG_HEIGHT=6, K=3, PIXEL_BITS=8, pixel=row*16+col.
- Continuous frame with pix_sof on first pixel -> 24 win_valid pulses. First valid follows pixel (2,2) with window rows {00,01,02},{10,11,12},{20,21,22}, MSB=00 and LSB=22. frame_done pulses with (5,7); frame_err never pulses.
- Same frame, pix_valid low on random 50% of cycles -> identical sequence of valid windows and coordinates; no outputs pulse during gaps.
- pix_sof reasserted on a pixel at (3,4) -> frame_err 1 cycle. Counters restart; no win_valid until new row 2, col 2. New first window = new frame data only.
- Reset asserted at (4,5) for 1 cycle -> all outputs 0. Next pixel (no sof) becomes (0,0); first win_valid after its (2,2).
- Two frames back-to-back, second with pixel=0xFF-(row*16+col) -> second frame's windows contain no first-frame values. frame_done pulses twice, 48 cycles apart.
